// File: rtl/dds_pkg.sv
// Shared definitions for the polyphonic DDS voice engine: MIDI status
// constants, playable note range, parser state encodings and the per-note
// phase increment table (A0..C8, ten times the note frequency in Hz).
package dds_pkg;

   localparam logic [7:0] MIDI_NOTE_ON  = 8'h90;
   localparam logic [7:0] MIDI_NOTE_OFF = 8'h80;
   localparam int         NOTE_LO       = 21;
   localparam int         NOTE_HI       = 108;
   localparam int         NOTE_CNT      = NOTE_HI - NOTE_LO + 1;
   localparam int         AGE_W         = 4;

   typedef enum logic [1:0] {PS_IDLE, PS_NOTE, PS_VEL, PS_COMMIT} parse_state_t;
   typedef enum logic [1:0] {RS_NONE, RS_OFF, RS_ON, RS_IGNORE}   run_status_t;

   localparam logic [15:0] NOTE_INC [NOTE_CNT] = '{
      16'd275,   16'd291,   16'd309,
      16'd327,   16'd346,   16'd367,   16'd389,   16'd412,   16'd437,
      16'd462,   16'd490,   16'd519,   16'd550,   16'd583,   16'd617,
      16'd654,   16'd693,   16'd734,   16'd778,   16'd824,   16'd873,
      16'd925,   16'd980,   16'd1038,  16'd1100,  16'd1165,  16'd1235,
      16'd1308,  16'd1386,  16'd1468,  16'd1556,  16'd1648,  16'd1746,
      16'd1850,  16'd1960,  16'd2077,  16'd2200,  16'd2331,  16'd2469,
      16'd2616,  16'd2772,  16'd2937,  16'd3111,  16'd3296,  16'd3492,
      16'd3700,  16'd3920,  16'd4153,  16'd4400,  16'd4662,  16'd4939,
      16'd5233,  16'd5544,  16'd5873,  16'd6223,  16'd6593,  16'd6985,
      16'd7400,  16'd7840,  16'd8306,  16'd8800,  16'd9323,  16'd9878,
      16'd10465, 16'd11087, 16'd11747, 16'd12445, 16'd13185, 16'd13969,
      16'd14800, 16'd15680, 16'd16612, 16'd17600, 16'd18647, 16'd19755,
      16'd20930, 16'd22175, 16'd23493, 16'd24890, 16'd26370, 16'd27938,
      16'd29600, 16'd31360, 16'd33224, 16'd35200, 16'd37293, 16'd39511,
      16'd41860
   };

   // Phase increment for a MIDI note; 0 outside the playable range.
   function automatic logic [15:0] note_inc(input logic [6:0] note);
      int idx;
      idx = int'(note) - NOTE_LO;
      if (idx < 0 || idx >= NOTE_CNT) return '0;
      return NOTE_INC[idx];
   endfunction

endpackage

// File: rtl/midi_byte_parser.sv
// MIDI byte parser: accepts bytes with a valid/ready handshake, tracks
// running status and emits a one-cycle note command (cmd_valid/cmd_on/
// cmd_note) from the COMMIT state. Out-of-range notes never raise cmd_valid.
module midi_byte_parser
   import dds_pkg::*;
(
   input  logic       clk,
   input  logic       nreset,
   input  logic       midi_valid,
   output logic       midi_ready,
   input  logic [7:0] midi_data,
   output logic       cmd_valid,
   output logic       cmd_on,
   output logic [6:0] cmd_note
);

   parse_state_t state_q, state_d;
   run_status_t  rs_q;
   logic [6:0]   note_q, vel_q;
   logic         accept, is_status, status_note, rs_valid, in_range;

   assign accept      = midi_valid && midi_ready;
   assign is_status   = midi_data[7];
   assign status_note = (midi_data[7:4] == MIDI_NOTE_ON[7:4]) ||
                        (midi_data[7:4] == MIDI_NOTE_OFF[7:4]);
   assign rs_valid    = (rs_q == RS_ON) || (rs_q == RS_OFF);

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) state_q <= PS_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; any status byte restarts the message.
   // NOTE: state_d gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      case (state_q)
         PS_IDLE: begin
            if (accept) begin
               if (is_status)     state_d = status_note ? PS_NOTE : PS_IDLE;
               else if (rs_valid) state_d = PS_VEL;
            end
         end
         PS_NOTE: begin
            if (accept) state_d = is_status ? (status_note ? PS_NOTE : PS_IDLE) : PS_VEL;
         end
         PS_VEL: begin
            if (accept) state_d = is_status ? (status_note ? PS_NOTE : PS_IDLE) : PS_COMMIT;
         end
         PS_COMMIT: state_d = PS_IDLE;
         default:   state_d = PS_IDLE;
      endcase
   end

   // Output logic: ready everywhere except the single COMMIT cycle.
   always_comb begin
      in_range   = (note_q >= 7'(NOTE_LO)) && (note_q <= 7'(NOTE_HI));
      midi_ready = (state_q != PS_COMMIT);
      cmd_valid  = (state_q == PS_COMMIT) && in_range;
      cmd_on     = (rs_q == RS_ON) && (vel_q != 7'd0);
      cmd_note   = note_q;
   end

   // Running status and message data capture.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         rs_q   <= RS_NONE;
         note_q <= '0;
         vel_q  <= '0;
      end else if (accept) begin
         if (is_status) begin
            if (status_note) rs_q <= midi_data[4] ? RS_ON : RS_OFF;
            else             rs_q <= RS_IGNORE;
         end else begin
            if (state_q == PS_NOTE || (state_q == PS_IDLE && rs_valid)) note_q <= midi_data[6:0];
            if (state_q == PS_VEL)                                       vel_q  <= midi_data[6:0];
         end
      end
   end

endmodule

// File: rtl/poly_dds_voice_engine.sv
// Polyphonic DDS voice engine: voice allocation from parsed MIDI commands,
// per-voice phase accumulators stepped at the sample tick, a time-multiplexed
// wavetable ROM scan and an unsigned mix of all active voices.
// Optional feature macro: VOICE_STEAL_EN (steal the oldest voice when full).
module poly_dds_voice_engine
   import dds_pkg::*;
#(
   parameter int NUM_VOICES = 8,
   parameter int PHASE_W    = 32,
   parameter int ADDR_W     = 10,
   parameter int SAMPLE_W   = 24,
   parameter int OUT_W      = 8,
   parameter int SAMPLE_DIV = 100,
   parameter int ROM_LAT    = 1
)(
   input  logic                  clk,
   input  logic                  nreset,
   input  logic                  midi_valid,
   output logic                  midi_ready,
   input  logic [7:0]            midi_data,
   output logic [ADDR_W-1:0]     rom_addr,
   input  logic [SAMPLE_W-1:0]   rom_q,
   output logic [OUT_W-1:0]      mix_out,
   output logic                  mix_valid,
   output logic [NUM_VOICES-1:0] voice_active,
   output logic                  note_dropped
);

   localparam int VW    = $clog2(NUM_VOICES);
   localparam int ACC_W = SAMPLE_W + VW;
   localparam int DIV_W = $clog2(SAMPLE_DIV);

   logic                cmd_valid, cmd_on;
   logic [6:0]          cmd_note;

   logic [DIV_W-1:0]    div_q;
   logic                tick;

   logic [NUM_VOICES-1:0] active_q, active_d, match_vec;
   logic [6:0]          note_q  [NUM_VOICES];
   logic [6:0]          note_d  [NUM_VOICES];
   logic [PHASE_W-1:0]  inc_q   [NUM_VOICES];
   logic [PHASE_W-1:0]  inc_d   [NUM_VOICES];
   logic [PHASE_W-1:0]  phase_q [NUM_VOICES];
   logic [PHASE_W-1:0]  phase_d [NUM_VOICES];

   logic                match_any, free_any, alloc, load, drop;
   logic [VW-1:0]       match_idx, free_idx, alloc_idx;

`ifdef VOICE_STEAL_EN
   logic [AGE_W-1:0]    age_q [NUM_VOICES];
   logic [AGE_W-1:0]    age_d [NUM_VOICES];
   logic [AGE_W-1:0]    old_age;
   logic [VW-1:0]       old_idx;
`endif

   logic [ADDR_W-1:0]   snap_addr_q [NUM_VOICES];
   logic [NUM_VOICES-1:0] snap_act_q;
   logic                scan_on_q;
   logic [ADDR_W-1:0]   rom_addr_q;
   logic [ACC_W-1:0]    acc_q, contrib, sum;
   logic [VW-1:0]       cap_idx;
   logic [OUT_W-1:0]    mix_out_q;
   logic                mix_valid_q;

   midi_byte_parser u_parser (
      .clk        (clk),
      .nreset     (nreset),
      .midi_valid (midi_valid),
      .midi_ready (midi_ready),
      .midi_data  (midi_data),
      .cmd_valid  (cmd_valid),
      .cmd_on     (cmd_on),
      .cmd_note   (cmd_note)
   );

   assign tick = (div_q == DIV_W'(SAMPLE_DIV - 1));

   // Sample-rate divider; the wrap back to 0 is the sample tick.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) div_q <= '0;
      else         div_q <= tick ? '0 : div_q + DIV_W'(1);
   end

   // Allocation decision for the command in COMMIT (lowest index wins every search).
   always_comb begin
      match_any = 1'b0;
      match_idx = '0;
      free_any  = 1'b0;
      free_idx  = '0;
      match_vec = '0;
      for (int v = NUM_VOICES - 1; v >= 0; v--) begin
         match_vec[v] = active_q[v] && (note_q[v] == cmd_note);
         if (match_vec[v]) begin
            match_any = 1'b1;
            match_idx = VW'(v);
         end
         if (!active_q[v]) begin
            free_any = 1'b1;
            free_idx = VW'(v);
         end
      end
`ifdef VOICE_STEAL_EN
      old_age = age_q[0];
      old_idx = '0;
      for (int v = 1; v < NUM_VOICES; v++) begin
         if (age_q[v] > old_age) begin
            old_age = age_q[v];
            old_idx = VW'(v);
         end
      end
`endif
      alloc     = 1'b0;
      load      = 1'b0;
      drop      = 1'b0;
      alloc_idx = '0;
      if (cmd_valid && cmd_on) begin
         if (match_any) begin
            alloc     = 1'b1;
            alloc_idx = match_idx;
         end else if (free_any) begin
            alloc     = 1'b1;
            load      = 1'b1;
            alloc_idx = free_idx;
         end else begin
`ifdef VOICE_STEAL_EN
            alloc     = 1'b1;
            load      = 1'b1;
            alloc_idx = old_idx;
`else
            drop      = 1'b1;
`endif
         end
      end
   end

   // Voice table next state: tick stepping first, then COMMIT overrides.
   always_comb begin
      for (int v = 0; v < NUM_VOICES; v++) begin
         active_d[v] = active_q[v];
         note_d[v]   = note_q[v];
         inc_d[v]    = inc_q[v];
         phase_d[v]  = phase_q[v];
         if (tick) phase_d[v] = active_q[v] ? phase_q[v] + inc_q[v] : '0;
         if (cmd_valid && !cmd_on && match_vec[v]) active_d[v] = 1'b0;
         if (alloc && alloc_idx == VW'(v)) begin
            active_d[v] = 1'b1;
            phase_d[v]  = '0;
            if (load) begin
               note_d[v] = cmd_note;
               inc_d[v]  = PHASE_W'(note_inc(cmd_note));
            end
         end
`ifdef VOICE_STEAL_EN
         age_d[v] = age_q[v];
         if (alloc) begin
            if (alloc_idx == VW'(v))                  age_d[v] = '0;
            else if (active_q[v] && age_q[v] != '1)   age_d[v] = age_q[v] + AGE_W'(1);
         end
`endif
      end
   end

   // Voice table registers.
   // NOTE: the voice table is a few flops, not a RAM, so it is reset explicitly to a known empty state.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         active_q <= '0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            note_q[v]  <= '0;
            inc_q[v]   <= '0;
            phase_q[v] <= '0;
         end
      end else begin
         active_q <= active_d;
         for (int v = 0; v < NUM_VOICES; v++) begin
            note_q[v]  <= note_d[v];
            inc_q[v]   <= inc_d[v];
            phase_q[v] <= phase_d[v];
         end
      end
   end

`ifdef VOICE_STEAL_EN
   // Voice ages used to pick the steal victim.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int v = 0; v < NUM_VOICES; v++) age_q[v] <= '0;
      end else begin
         for (int v = 0; v < NUM_VOICES; v++) age_q[v] <= age_d[v];
      end
   end
`endif

   // Mix datapath: ROM word of the voice captured this cycle, added to the running sum.
   always_comb begin
      cap_idx = VW'(int'(div_q) - ROM_LAT);
      contrib = snap_act_q[cap_idx] ? ACC_W'(rom_q) : '0;
      sum     = ((int'(div_q) == ROM_LAT) ? '0 : acc_q) + contrib;
   end

   // Scan sequencer: snapshot at tick, drive one ROM address per cycle, accumulate, publish.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         scan_on_q   <= 1'b0;
         snap_act_q  <= '0;
         for (int v = 0; v < NUM_VOICES; v++) snap_addr_q[v] <= '0;
         rom_addr_q  <= '0;
         acc_q       <= '0;
         mix_out_q   <= '0;
         mix_valid_q <= 1'b0;
      end else begin
         mix_valid_q <= 1'b0;
         if (tick) begin
            scan_on_q  <= 1'b1;
            snap_act_q <= active_d;
            for (int v = 0; v < NUM_VOICES; v++) snap_addr_q[v] <= phase_d[v][PHASE_W-1 -: ADDR_W];
            rom_addr_q <= phase_d[0][PHASE_W-1 -: ADDR_W];
         end else if (scan_on_q) begin
            if (int'(div_q) < NUM_VOICES - 1) rom_addr_q <= snap_addr_q[VW'(int'(div_q) + 1)];
            if (int'(div_q) >= ROM_LAT && int'(div_q) < NUM_VOICES + ROM_LAT) begin
               acc_q <= sum;
               if (int'(div_q) == NUM_VOICES + ROM_LAT - 1) begin
                  mix_out_q   <= OUT_W'(sum >> (ACC_W - OUT_W));
                  mix_valid_q <= 1'b1;
                  scan_on_q   <= 1'b0;
               end
            end
         end
      end
   end

   assign rom_addr     = rom_addr_q;
   assign mix_out      = mix_out_q;
   assign mix_valid    = mix_valid_q;
   assign voice_active = active_q;
   assign note_dropped = drop;

endmodule

// File: tb/tb_poly_dds_voice_engine.sv
// Directed bench for poly_dds_voice_engine with a constant-word ROM model.
// Expectations follow VOICE_STEAL_EN when the bench is built with it.
module tb_poly_dds_voice_engine;

   localparam int NV   = 8;
   localparam int DIV  = 100;
   localparam int RLAT = 1;

   logic          clk = 1'b0;
   logic          nreset;
   logic          midi_valid;
   logic          midi_ready;
   logic [7:0]    midi_data;
   logic [9:0]    rom_addr;
   logic [23:0]   rom_q = '0;
   logic [7:0]    mix_out;
   logic          mix_valid;
   logic [NV-1:0] voice_active;
   logic          note_dropped;

   logic [23:0]   rom_word;
   int            total = 0;
   int            bad   = 0;
   int            cyc;
   int            mv_cnt = 0;
   int            mv_cyc = 0;
   int            drop_cnt = 0;

   poly_dds_voice_engine #(
      .NUM_VOICES(NV), .PHASE_W(32), .ADDR_W(10), .SAMPLE_W(24),
      .OUT_W(8), .SAMPLE_DIV(DIV), .ROM_LAT(RLAT)
   ) dut (
      .clk          (clk),
      .nreset       (nreset),
      .midi_valid   (midi_valid),
      .midi_ready   (midi_ready),
      .midi_data    (midi_data),
      .rom_addr     (rom_addr),
      .rom_q        (rom_q),
      .mix_out      (mix_out),
      .mix_valid    (mix_valid),
      .voice_active (voice_active),
      .note_dropped (note_dropped)
   );

   always #5 clk = ~clk;

   // One-cycle-latency ROM returning a bench-selected word.
   always @(posedge clk) rom_q <= rom_word;

   // Edges since reset release; equals the divider value modulo DIV.
   always @(posedge clk or negedge nreset) begin
      if (!nreset) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   // Pulse monitor.
   always @(negedge clk) begin
      if (nreset) begin
         if (mix_valid) begin
            mv_cnt++;
            mv_cyc = cyc;
         end
         if (note_dropped) drop_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      midi_valid = 1'b1;
      midi_data  = b;
      while (!midi_ready && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("ready", midi_ready, 1);
      @(posedge clk);
      #1;
      midi_valid = 1'b0;
   endtask

   task automatic send_msg(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      send_byte(b0);
      if (n > 1) send_byte(b1);
      if (n > 2) send_byte(b2);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_mv();
      int n0 = mv_cnt;
      int k  = 0;
      while (mv_cnt == n0 && k < 400) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("mv_seen", mv_cnt != n0, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mix_out"},  mix_out, 0);
      check({tag, "_mix_valid"}, mix_valid, 0);
      check({tag, "_rom_addr"}, rom_addr, 0);
      check({tag, "_active"},   voice_active, 0);
      check({tag, "_dropped"},  note_dropped, 0);
      check({tag, "_ready"},    midi_ready, 1);
   endtask

   initial begin
      nreset     = 1'b0;
      midi_valid = 1'b0;
      midi_data  = 8'h00;
      rom_word   = 24'hC00000;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      nreset = 1'b1;

      // Single note A4: phase steps by 4400 per tick, one voice mixed.
      send_msg(3, 8'h90, 8'h45, 8'h64);
      check("t2_active", voice_active, 32'h01);
      wait_mv();
      check("t2_mv_cyc1", mv_cyc, DIV + NV + RLAT);
      check("t2_phase1", dut.phase_q[0], 4400);
      check("t2_mix", mix_out, 8'h18);
      @(negedge clk);
      check("t2_mv_pulse", mix_valid, 0);
      wait_mv();
      check("t2_mv_cyc2", mv_cyc, 2 * DIV + NV + RLAT);
      check("t2_phase2", dut.phase_q[0], 8800);
      wait_mv();
      check("t2_phase3", dut.phase_q[0], 13200);

      // Reset asserted in the middle of a scan, held for 3 cycles.
      while (cyc != 4 * DIV + 3) @(negedge clk);
      nreset = 1'b0;
      #1;
      check_reset_outputs("rst_now");
      repeat (3) @(negedge clk);
      check_reset_outputs("rst_end");
      nreset = 1'b1;

      // Note on, running-status note on, note off.
      send_msg(3, 8'h90, 8'h3C, 8'h40);
      check("t3_on1", voice_active, 32'h01);
      send_msg(2, 8'h3E, 8'h40, 8'h00);
      check("t3_run", voice_active, 32'h03);
      send_msg(3, 8'h80, 8'h3C, 8'h00);
      check("t3_off", voice_active, 32'h02);

      // Velocity 0, out-of-range notes, foreign status bytes.
      send_msg(3, 8'h90, 8'h3C, 8'h40);
      check("t4_on", voice_active, 32'h03);
      send_msg(3, 8'h90, 8'h3C, 8'h00);
      check("t4_vel0", voice_active, 32'h02);
      send_msg(3, 8'h90, 8'h14, 8'h40);
      check("t4_note20", voice_active, 32'h02);
      send_msg(3, 8'hF8, 8'h40, 8'h40);
      check("t4_ignore_rs", voice_active, 32'h02);
      send_byte(8'hF8);
      send_msg(3, 8'h90, 8'h3C, 8'h40);
      check("t4_after_f8", voice_active, 32'h03);
      send_msg(3, 8'h80, 8'h3C, 8'h00);
      send_msg(2, 8'h3E, 8'h00, 8'h00);
      check("t4_clear", voice_active, 32'h00);
      send_msg(3, 8'h90, 8'h6D, 8'h40);
      check("t4_note109", voice_active, 32'h00);
      check("t4_no_drop", drop_cnt, 0);

      // Fill all voices (range ends included), then a ninth note.
      send_msg(3, 8'h90, 8'h15, 8'h40);
      send_msg(2, 8'h1E, 8'h40, 8'h00);
      send_msg(2, 8'h28, 8'h40, 8'h00);
      send_msg(2, 8'h32, 8'h40, 8'h00);
      send_msg(2, 8'h3C, 8'h40, 8'h00);
      send_msg(2, 8'h46, 8'h40, 8'h00);
      send_msg(2, 8'h50, 8'h40, 8'h00);
      send_msg(2, 8'h6C, 8'h40, 8'h00);
      check("t5_full", voice_active, 32'hFF);
      send_msg(2, 8'h5A, 8'h40, 8'h00);
      check("t5_ninth", voice_active, 32'hFF);
`ifdef VOICE_STEAL_EN
      check("t5_drops", drop_cnt, 0);
      send_msg(3, 8'h80, 8'h15, 8'h00);
      check("t5_off21", voice_active, 32'hFF);
      send_msg(2, 8'h5A, 8'h00, 8'h00);
      check("t5_off90", voice_active, 32'hFE);
`else
      check("t5_drops", drop_cnt, 1);
      send_msg(3, 8'h80, 8'h15, 8'h00);
      check("t5_off21", voice_active, 32'hFE);
`endif
      send_msg(3, 8'h90, 8'h5A, 8'h40);
      check("t5_refill", voice_active, 32'hFF);
`ifdef VOICE_STEAL_EN
      check("t5_drops2", drop_cnt, 0);
`else
      check("t5_drops2", drop_cnt, 1);
`endif

      // Retrigger of voice 3 (note 50) landing on the sample tick; full-scale ROM.
      rom_word = 24'hFFFFFF;
      begin
         int k = 0;
         while ((cyc % DIV) != DIV - 5 && k < 3 * DIV) begin
            @(negedge clk);
            k++;
         end
         check("t6_sync", cyc % DIV, DIV - 5);
      end
      send_byte(8'h90);
      send_byte(8'h32);
      send_byte(8'h40);
      repeat (2) @(negedge clk);
      check("t6_at_wrap", cyc % DIV, 0);
      check("t6_phase3", dut.phase_q[3], 0);
      check("t6_active", voice_active, 32'hFF);
      wait_mv();
      check("t6_mv_pos", mv_cyc % DIV, NV + RLAT);
      check("t6_mix", mix_out, 8'hFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
